// File: rtl/data_mem_responder_if.sv
// Data-port bundle between the RV32I core (master) and the data memory responder (slave).
// Signal names are written from the responder's side: i_* go into the memory, o_* come out.
interface data_mem_responder_if;
  logic        i_data_rd_en_ma;
  logic        i_data_wr_en_ma;
  logic [1:0]  i_data_ctrl;
  logic [31:0] i_data_addr;
  logic [31:0] i_data_wr;
  logic        o_data_ready;
  logic [31:0] o_data_rd;
  logic        o_data_err;

  modport master (
    output i_data_rd_en_ma, i_data_wr_en_ma, i_data_ctrl, i_data_addr, i_data_wr,
    input  o_data_ready, o_data_rd, o_data_err
  );

  modport slave (
    input  i_data_rd_en_ma, i_data_wr_en_ma, i_data_ctrl, i_data_addr, i_data_wr,
    output o_data_ready, o_data_rd, o_data_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: word-organised RAM with byte-lane steering and a programmable
// wait-state count between request acceptance and the one-cycle ready pulse.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN (flag and suppress misaligned accesses;
// when undefined, low address bits are masked to natural alignment instead).
//
// state  | meaning
// S_IDLE | waiting for rd_en/wr_en; request latched on acceptance
// S_WAIT | counting wait states; RAM access happens on the edge leaving here
// S_RESP | o_data_ready high for this single cycle
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input logic               clk,
  input logic               rst_n,
  data_mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // With no wait states the RAM access shares the acceptance edge, so it must use the
  // live request instead of the latched copy.
  localparam bit DIRECT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_store;
  logic [1:0]  r_ctrl;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_commit;
  logic          w_c_store;
  logic [1:0]    w_c_ctrl;
  logic [31:0]   w_c_addr;
  logic [31:0]   w_c_wdata;
  logic          w_byte;
  logic          w_half;
  logic [1:0]    w_off;
  logic          w_misalign;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata_rep;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic [31:0]   w_lane;
  logic [31:0]   w_load_data;
  logic          w_mem_we;
  logic          w_unused;

  assign w_accept  = (r_state == S_IDLE) && (bus.i_data_rd_en_ma || bus.i_data_wr_en_ma);
  assign w_commit  = rst_n && (DIRECT ? w_accept : ((r_state == S_WAIT) && (r_cnt == 4'd1)));
  assign w_c_store = DIRECT ? bus.i_data_wr_en_ma : r_store;
  assign w_c_ctrl  = DIRECT ? bus.i_data_ctrl     : r_ctrl;
  assign w_c_addr  = DIRECT ? bus.i_data_addr     : r_addr;
  assign w_c_wdata = DIRECT ? bus.i_data_wr       : r_wdata;
  assign w_byte    = (w_c_ctrl == 2'b00);
  assign w_half    = (w_c_ctrl == 2'b01);
  assign w_idx     = w_c_addr[2 +: AW];
  assign w_word    = r_mem[w_idx];
  assign w_mem_we  = w_commit && w_c_store && !w_misalign;
  // Address bits above the RAM index alias by design.
  assign w_unused  = &{1'b0, w_c_addr[31:2+AW]};

  // Decode alignment, byte enables, write-data replication and load lane extraction.
  always_comb begin
    w_off      = w_c_addr[1:0];
    w_misalign = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
    w_misalign = (w_half && w_c_addr[0]) || (!w_half && !w_byte && (w_c_addr[1:0] != 2'b00));
`else
    if (w_half)       w_off[0] = 1'b0;
    else if (!w_byte) w_off    = 2'b00;
`endif
    if (w_byte) begin
      w_be        = 4'b0001 << w_off;
      w_wdata_rep = {4{w_c_wdata[7:0]}};
    end else if (w_half) begin
      w_be        = w_off[1] ? 4'b1100 : 4'b0011;
      w_wdata_rep = {2{w_c_wdata[15:0]}};
    end else begin
      w_be        = 4'b1111;
      w_wdata_rep = w_c_wdata;
    end
    w_lane = w_word >> {w_off, 3'b000};
    if (w_misalign)   w_load_data = 32'd0;
    else if (w_byte)  w_load_data = {24'd0, w_lane[7:0]};
    else if (w_half)  w_load_data = {16'd0, w_lane[15:0]};
    else              w_load_data = w_word;
  end

  // RAM byte-lane write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
      end
    end
  end

  // Request sequencing with registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_cnt            <= 4'd0;
      r_store          <= 1'b0;
      r_ctrl           <= 2'b00;
      r_addr           <= 32'd0;
      r_wdata          <= 32'd0;
      bus.o_data_ready <= 1'b0;
      bus.o_data_rd    <= 32'd0;
      bus.o_data_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          bus.o_data_ready <= 1'b0;
          bus.o_data_err   <= 1'b0;
          if (w_accept) begin
            r_store <= bus.i_data_wr_en_ma;
            r_ctrl  <= bus.i_data_ctrl;
            r_addr  <= bus.i_data_addr;
            r_wdata <= bus.i_data_wr;
            if (DIRECT) begin
              r_state          <= S_RESP;
              bus.o_data_ready <= 1'b1;
              bus.o_data_rd    <= w_c_store ? 32'd0 : w_load_data;
              bus.o_data_err   <= w_misalign;
            end else begin
              r_cnt   <= 4'(WAIT_CYCLES);
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state          <= S_RESP;
            bus.o_data_ready <= 1'b1;
            bus.o_data_rd    <= w_c_store ? 32'd0 : w_load_data;
            bus.o_data_err   <= w_misalign;
          end
        end
        S_RESP: begin
          bus.o_data_ready <= 1'b0;
          bus.o_data_err   <= 1'b0;
          r_state          <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
